// File: rtl/calc_mp_pkg.sv
// Shared types for the multi-port calculator engine.
package calc_mp_pkg;

  localparam int CMD_W      = 4;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_TAG_W  = 2;

  typedef enum logic [CMD_W-1:0] {
    NOP = 4'd0,
    ADD = 4'd1,
    SUB = 4'd2,
    SHL = 4'd5,
    SHR = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_ERR  = 2'd2
  } resp_e;

  typedef enum logic {
    CAP_IDLE     = 1'b0,
    CAP_WAIT_OP2 = 1'b1
  } cap_state_e;

  typedef struct packed {
    logic [CMD_W-1:0]      cmd;
    logic [DEF_DATA_W-1:0] op1;
    logic [DEF_DATA_W-1:0] op2;
    logic [DEF_TAG_W-1:0]  tag;
  } req_t;

endpackage

// File: rtl/calc_mp_fifo.sv
// Per-port command queue: synchronous push/pop, registered occupancy count.
module calc_mp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   c_clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge c_clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/calc_mp_engine.sv
// Multi-port calculator: per-port capture FSM + FIFO, round-robin arbiter,
// shared two-stage ALU pipeline with responses routed back to the source port.
module calc_mp_engine
  import calc_mp_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 2,
  parameter int DEPTH     = 4
) (
  input  logic                          c_clk,
  input  logic                          reset_n,
  input  logic [NUM_PORTS*CMD_W-1:0]    req_cmd_in,
  input  logic [NUM_PORTS*DATA_W-1:0]   req_data_in,
  input  logic [NUM_PORTS*TAG_W-1:0]    req_tag_in,
  output logic [NUM_PORTS-1:0]          req_ready,
  output logic [NUM_PORTS*2-1:0]        out_resp,
  output logic [NUM_PORTS*DATA_W-1:0]   out_data,
  output logic [NUM_PORTS*TAG_W-1:0]    out_tag
);

  localparam int FW  = CMD_W + 2 * DATA_W + TAG_W;
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int SHW = $clog2(DATA_W);

  // Returns {error, result}; a failing command always carries a zero result.
  function automatic logic [DATA_W:0] alu(input logic [CMD_W-1:0]  cmd,
                                          input logic [DATA_W-1:0] a,
                                          input logic [DATA_W-1:0] b);
    logic [DATA_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    case (cmd)
      ADD:     alu = sum[DATA_W] ? {1'b1, {DATA_W{1'b0}}} : {1'b0, sum[DATA_W-1:0]};
      SUB:     alu = (b > a) ? {1'b1, {DATA_W{1'b0}}} : {1'b0, a - b};
      SHL:     alu = {1'b0, a << b[SHW-1:0]};
      SHR:     alu = {1'b0, a >> b[SHW-1:0]};
      default: alu = {1'b1, {DATA_W{1'b0}}};
    endcase
  endfunction

  logic                 ready_en;
  logic [NUM_PORTS-1:0] nonempty;
  logic [NUM_PORTS-1:0] pop_vec;
  logic [FW-1:0]        rd_data [NUM_PORTS];

  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        cand;
  logic                 gnt_vld_p0;
  logic [PW-1:0]        gnt_p0;

  logic                 vld_p1;
  logic [CMD_W-1:0]     cmd_p1;
  logic [DATA_W-1:0]    op1_p1;
  logic [DATA_W-1:0]    op2_p1;
  logic [TAG_W-1:0]     tag_p1;
  logic [PW-1:0]        port_p1;
  logic [DATA_W:0]      alu_p1;

  logic                 vld_p2;
  logic                 err_p2;
  logic [DATA_W-1:0]    res_p2;
  logic [TAG_W-1:0]     tag_p2;
  logic [PW-1:0]        port_p2;

  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) ready_en <= 1'b0;
    else          ready_en <= 1'b1;
  end

  // Stage p0: per-port capture and queueing
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    cap_state_e        state;
    logic [CMD_W-1:0]  cmd_now;
    logic [CMD_W-1:0]  cmd_lat;
    logic [DATA_W-1:0] op1_lat;
    logic [TAG_W-1:0]  tag_lat;
    logic [CW-1:0]     cnt;
    logic              take;
    logic              push;
    logic              hit;

    assign cmd_now = req_cmd_in[p*CMD_W +: CMD_W];
    assign take    = (state == CAP_IDLE) && (cmd_now != '0) && req_ready[p];
    assign push    = (state == CAP_WAIT_OP2);

    always_ff @(posedge c_clk or negedge reset_n) begin
      if (!reset_n) begin
        state <= CAP_IDLE;
      end else begin
        case (state)
          CAP_IDLE:     if (take) state <= CAP_WAIT_OP2;
          CAP_WAIT_OP2: state <= CAP_IDLE;
          default:      state <= CAP_IDLE;
        endcase
      end
    end

    always_ff @(posedge c_clk) begin
      if (take) begin
        cmd_lat <= cmd_now;
        op1_lat <= req_data_in[p*DATA_W +: DATA_W];
        tag_lat <= req_tag_in[p*TAG_W +: TAG_W];
      end
    end

    // The last free slot is held back for the op2 of a command already in flight.
    assign req_ready[p] = ready_en &&
                          ((cnt < CW'(DEPTH - 1)) ||
                           ((cnt == CW'(DEPTH - 1)) && (state == CAP_IDLE)));

    calc_mp_fifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .c_clk     (c_clk),
      .reset_n   (reset_n),
      .push      (push),
      .push_data ({cmd_lat, op1_lat, req_data_in[p*DATA_W +: DATA_W], tag_lat}),
      .pop       (pop_vec[p]),
      .pop_data  (rd_data[p]),
      .count     (cnt)
    );

    assign nonempty[p] = (cnt != '0);

    assign hit = vld_p2 && (port_p2 == PW'(p));
    assign out_resp[p*2 +: 2]          = hit ? (err_p2 ? RESP_ERR : RESP_OK) : RESP_NONE;
    assign out_data[p*DATA_W +: DATA_W] = (hit && !err_p2) ? res_p2 : '0;
    assign out_tag[p*TAG_W +: TAG_W]    = hit ? tag_p2 : '0;
  end

  always_comb begin
    gnt_vld_p0 = 1'b0;
    gnt_p0     = '0;
    cand       = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = PW'((int'(rr_ptr) + k) % NUM_PORTS);
      if (!gnt_vld_p0 && nonempty[cand]) begin
        gnt_vld_p0 = 1'b1;
        gnt_p0     = cand;
      end
    end
  end

  always_comb begin
    pop_vec = '0;
    if (gnt_vld_p0) pop_vec[gnt_p0] = 1'b1;
  end

  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n)        rr_ptr <= '0;
    else if (gnt_vld_p0) rr_ptr <= PW'((int'(gnt_p0) + 1) % NUM_PORTS);
  end

  // Stage p1: granted request held for execution
  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) vld_p1 <= 1'b0;
    else          vld_p1 <= gnt_vld_p0;
  end

  always_ff @(posedge c_clk) begin
    if (gnt_vld_p0) begin
      {cmd_p1, op1_p1, op2_p1, tag_p1} <= rd_data[gnt_p0];
      port_p1                          <= gnt_p0;
    end
  end

  assign alu_p1 = alu(cmd_p1, op1_p1, op2_p1);

  // Stage p2: result register driving the addressed port for one cycle
  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) vld_p2 <= 1'b0;
    else          vld_p2 <= vld_p1;
  end

  always_ff @(posedge c_clk) begin
    if (vld_p1) begin
      err_p2  <= alu_p1[DATA_W];
      res_p2  <= alu_p1[DATA_W-1:0];
      tag_p2  <= tag_p1;
      port_p2 <= port_p1;
    end
  end

endmodule

// File: tb/tb_calc_mp_engine.sv
module tb_calc_mp_engine;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int TW = 2;

  logic c_clk   = 1'b0;
  logic reset_n = 1'b0;

  logic [NP*4-1:0]  cmd_a  = '0, cmd_b  = '0;
  logic [NP*DW-1:0] data_a = '0, data_b = '0;
  logic [NP*TW-1:0] tag_a  = '0, tag_b  = '0;
  logic [NP-1:0]    rdy_a, rdy_b;
  logic [NP*2-1:0]  resp_a, resp_b;
  logic [NP*DW-1:0] od_a, od_b;
  logic [NP*TW-1:0] ot_a, ot_b;

  always #5 c_clk = ~c_clk;

  int cyc = 0;
  always @(posedge c_clk) cyc <= cyc + 1;

  calc_mp_engine #(.NUM_PORTS(NP), .DATA_W(DW), .TAG_W(TW), .DEPTH(4)) dut_a (
    .c_clk(c_clk), .reset_n(reset_n),
    .req_cmd_in(cmd_a), .req_data_in(data_a), .req_tag_in(tag_a),
    .req_ready(rdy_a), .out_resp(resp_a), .out_data(od_a), .out_tag(ot_a)
  );

  calc_mp_engine #(.NUM_PORTS(NP), .DATA_W(DW), .TAG_W(TW), .DEPTH(2)) dut_b (
    .c_clk(c_clk), .reset_n(reset_n),
    .req_cmd_in(cmd_b), .req_data_in(data_b), .req_tag_in(tag_b),
    .req_ready(rdy_b), .out_resp(resp_b), .out_data(od_b), .out_tag(ot_b)
  );

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    logic [1:0]  tag;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  er;
    logic [31:0] ed;
  } vec_t;

  exp_t sb [2*NP][$];
  int   total = 0;
  int   bad   = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // Independent reference for the ALU: returns {resp, data}.
  function automatic logic [33:0] model(input logic [3:0] c, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (c)
      4'd1:    model = s[32] ? {2'd2, 32'h0} : {2'd1, s[31:0]};
      4'd2:    model = (b > a) ? {2'd2, 32'h0} : {2'd1, a - b};
      4'd5:    model = {2'd1, a << (b % 32)};
      4'd6:    model = {2'd1, a >> (b % 32)};
      default: model = {2'd2, 32'h0};
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (cyc=%0d)", name, got, want, cyc);
    end
  endtask

  task automatic chk_port(input int qi, input logic [1:0] r, input logic [31:0] d,
                          input logic [1:0] t);
    exp_t e;
    total++;
    if (r != 2'd0) begin
      if (sb[qi].size() == 0) begin
        bad++;
        $display("FAIL unexpected_resp q%0d cyc=%0d: got resp=%0d data=%h tag=%0d, want none",
                 qi, cyc, r, d, t);
      end else begin
        e = sb[qi].pop_front();
        if (r !== e.resp || d !== e.data || t !== e.tag || (e.cyc >= 0 && e.cyc != cyc)) begin
          bad++;
          $display("FAIL resp_check q%0d: got resp=%0d data=%h tag=%0d cyc=%0d, want resp=%0d data=%h tag=%0d cyc=%0d",
                   qi, r, d, t, cyc, e.resp, e.data, e.tag, e.cyc);
        end
      end
    end else if (d != '0 || t != '0) begin
      bad++;
      $display("FAIL idle_outputs q%0d cyc=%0d: got data=%h tag=%0d, want 0", qi, cyc, d, t);
    end else if (sb[qi].size() != 0 && sb[qi][0].cyc >= 0 && cyc >= sb[qi][0].cyc) begin
      e = sb[qi].pop_front();
      bad++;
      $display("FAIL missing_resp q%0d: got resp=0 at cyc=%0d, want resp=%0d tag=%0d at cyc=%0d",
               qi, cyc, e.resp, e.tag, e.cyc);
    end
  endtask

  // One clock: advance to the falling edge, then check every output port of both DUTs.
  task automatic step();
    @(negedge c_clk);
    for (int p = 0; p < NP; p++) begin
      chk_port(p,      resp_a[p*2 +: 2], od_a[p*DW +: DW], ot_a[p*TW +: TW]);
      chk_port(NP + p, resp_b[p*2 +: 2], od_b[p*DW +: DW], ot_b[p*TW +: TW]);
    end
  endtask

  task automatic drv_a(input int p, input logic [3:0] c, input logic [31:0] d, input logic [1:0] t);
    cmd_a[p*4 +: 4]   = c;
    data_a[p*DW +: DW] = d;
    tag_a[p*TW +: TW]  = t;
  endtask

  task automatic drv_b(input int p, input logic [3:0] c, input logic [31:0] d, input logic [1:0] t);
    cmd_b[p*4 +: 4]   = c;
    data_b[p*DW +: DW] = d;
    tag_b[p*TW +: TW]  = t;
  endtask

  task automatic issue1(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] t, input logic [1:0] er, input logic [31:0] ed);
    exp_t e;
    check("ready_before_issue", 64'(rdy_a[p]), 64'd1);
    drv_a(p, c, a, t);
    step();
    drv_a(p, 4'd0, b, 2'd0);
    e.resp = er; e.data = ed; e.tag = t; e.cyc = cyc + 3;
    sb[p].push_back(e);
    step();
    drv_a(p, 4'd0, 32'h0, 2'd0);
  endtask

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < 2*NP; i++) n += sb[i].size();
    return n;
  endfunction

  vec_t        vt [10];
  logic [3:0]  ops [5];
  logic [3:0]  acc;
  logic [3:0]  cmds [NP];
  logic [31:0] op1s [NP];
  logic [1:0]  tags [NP];

  initial begin
    exp_t        e;
    logic [33:0] m;
    logic [31:0] o2;

    vt[0] = '{4'd1, 32'h30,       32'h20, 2'd1, 32'h50};
    vt[1] = '{4'd1, 32'hFFFFFFFF, 32'h1,  2'd2, 32'h0};
    vt[2] = '{4'd2, 32'h10,       32'h20, 2'd2, 32'h0};
    vt[3] = '{4'd3, 32'h5,        32'h6,  2'd2, 32'h0};
    vt[4] = '{4'd5, 32'h1,        32'h24, 2'd1, 32'h10};
    vt[5] = '{4'd6, 32'h80000000, 32'h1F, 2'd1, 32'h1};
    vt[6] = '{4'd2, 32'h50,       32'h20, 2'd1, 32'h30};
    vt[7] = '{4'd1, 32'hFFFFFFFE, 32'h1,  2'd1, 32'hFFFFFFFF};
    vt[8] = '{4'd15, 32'h1,       32'h1,  2'd2, 32'h0};
    vt[9] = '{4'd2, 32'h20,       32'h20, 2'd1, 32'h0};
    ops[0] = 4'd1; ops[1] = 4'd2; ops[2] = 4'd5; ops[3] = 4'd6; ops[4] = 4'd3;

    // Reset state
    repeat (3) step();
    check("reset_ready_a", 64'(rdy_a), 64'h0);
    check("reset_ready_b", 64'(rdy_b), 64'h0);
    check("reset_resp_a",  64'(resp_a), 64'h0);
    check("reset_data_a",  64'(|od_a), 64'h0);
    check("reset_tag_a",   64'(ot_a), 64'h0);
    #2 reset_n = 1'b1;
    #1 check("ready_before_first_edge", 64'(rdy_a), 64'h0);
    step();
    check("ready_after_first_edge_a", 64'(rdy_a), 64'hF);
    check("ready_after_first_edge_b", 64'(rdy_b), 64'hF);

    // Port 0 add with exact latency; other ports must stay silent
    issue1(0, 4'd1, 32'h30, 32'h20, 2'd1, 2'd1, 32'h50);
    repeat (4) step();

    // Table of single commands rotating over the ports
    for (int i = 0; i < 10; i++) begin
      issue1(i % NP, vt[i].c, vt[i].a, vt[i].b, 2'(i + 1), vt[i].er, vt[i].ed);
      repeat (4) step();
    end

    // Reset in the middle of traffic
    for (int p = 0; p < NP; p++) drv_a(p, 4'd1, 32'h1000 + 32'(p), 2'(p));
    step();
    for (int p = 0; p < NP; p++) begin
      drv_a(p, 4'd0, 32'h1, 2'd0);
      e.resp = 2'd1; e.data = 32'h1001 + 32'(p); e.tag = 2'(p); e.cyc = -1;
      sb[p].push_back(e);
    end
    step();
    for (int p = 0; p < NP; p++) drv_a(p, 4'd0, 32'h0, 2'd0);
    repeat (2) step();
    #2 reset_n = 1'b0;
    #1;
    check("midreset_resp_zero",  64'(resp_a), 64'h0);
    check("midreset_data_zero",  64'(|od_a), 64'h0);
    check("midreset_ready_zero", 64'(rdy_a), 64'h0);
    for (int i = 0; i < 2*NP; i++) sb[i].delete();
    step();
    #2 reset_n = 1'b1;
    repeat (6) step();
    issue1(3, 4'd2, 32'h77, 32'h7, 2'd2, 2'd1, 32'h70);
    repeat (4) step();

    // All four ports issue together: responses in port order on consecutive cycles
    for (int p = 0; p < NP; p++) drv_a(p, 4'd1, 32'h100 * 32'(p + 1), 2'(p));
    step();
    for (int p = 0; p < NP; p++) begin
      drv_a(p, 4'd0, 32'(p), 2'd0);
      e.resp = 2'd1; e.data = 32'h100 * 32'(p + 1) + 32'(p); e.tag = 2'(p); e.cyc = cyc + 3 + p;
      sb[p].push_back(e);
    end
    step();
    for (int p = 0; p < NP; p++) drv_a(p, 4'd0, 32'h0, 2'd0);
    repeat (8) step();

    // Shallow FIFOs under back-to-back load from every port
    acc = '0;
    for (int j = 0; j < 24; j++) begin
      if (j % 2 == 0) begin
        if (j == 4) check("ready_backpressure_b", 64'(rdy_b), 64'h3);
        for (int p = 0; p < NP; p++) begin
          cmds[p] = ops[$urandom_range(0, 4)];
          op1s[p] = (p % 2 == 0) ? $urandom : 32'($urandom_range(0, 5000));
          tags[p] = 2'($urandom_range(0, 3));
          acc[p]  = rdy_b[p];
          drv_b(p, cmds[p], op1s[p], tags[p]);
        end
      end else begin
        for (int p = 0; p < NP; p++) begin
          o2 = (p < 2) ? $urandom : 32'($urandom_range(0, 5000));
          drv_b(p, 4'd0, o2, 2'd0);
          if (acc[p]) begin
            m = model(cmds[p], op1s[p], o2);
            e.resp = m[33:32]; e.data = m[31:0]; e.tag = tags[p]; e.cyc = -1;
            sb[NP + p].push_back(e);
          end
        end
      end
      step();
    end
    for (int p = 0; p < NP; p++) drv_b(p, 4'd0, 32'h0, 2'd0);

    for (int w = 0; w < 100 && pending() != 0; w++) step();
    repeat (4) step();
    for (int i = 0; i < 2*NP; i++) check($sformatf("queue_drained_q%0d", i), 64'(sb[i].size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
